mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory responder for the load/store stage's memory request interface.
- The initiator raises mem_r or mem_w and holds it until it sees ok.
- This block latches the request, waits a programmable latency, performs the access on an internal 64-bit-wide RAM, then pulses ok for one cycle with read data.
- It sits between the memory stage and the data RAM, standing in for the data bus / D-cache.

Parameters:
- DEPTH, 256, number of 64-bit words in the internal RAM; power of two, at least 2.
- LATENCY, 2, cycles from the accepting edge to ok assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_r  input  1  read request; level, held by the initiator until ok.
- mem_w  input  1  write request; level, held by the initiator until ok.
- addr  input  64  byte address; word index = addr[$clog2(DEPTH)+2:3].
- wdata  input  64  write data, lane-aligned to the 64-bit word.
- wstrb  input  8  byte-lane write enables; bit i selects wdata[8i+7:8i].
- rdata  output  64  read data; valid while ok=1, held afterwards.
- ok  output  1  one-cycle completion pulse for both reads and writes.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset=1): state=IDLE, ok=0, busy=0, rdata=0, latency counter=0. RAM contents are not cleared.
- Reset mid-operation: the in-flight access is dropped. A write that has not reached its access edge must not modify the RAM.
- States:
  - IDLE: if (mem_r|mem_w) at the rising edge, latch addr, wdata, wstrb and op (write if mem_w=1, else read). Then:
    - if LATENCY=1, perform the access and go to RESP;
    - otherwise cnt<=LATENCY-2 and go to WAIT.
  - WAIT: if cnt==0, perform the access and go to RESP; else cnt<=cnt-1.
  - RESP: ok=1 for exactly this cycle; go to DONE.
  - DONE: ok=0. Go to IDLE once mem_r=0 and mem_w=0 are sampled. This prevents a held request from being re-accepted.
- Latency: ok is high in the cycle that begins exactly LATENCY edges after the accepting edge.
- Request input changes: changes to addr, wdata or wstrb after acceptance are ignored; the latched copies are used.
- Access edge, read: rdata <= RAM[idx] (full 64-bit word). Byte/half/word extraction and sign extension belong to the initiator.
- Access edge, write: for each i with wstrb[i]=1, RAM[idx][8i+7:8i] <= wdata[8i+7:8i]. rdata is unchanged. A write with wstrb=0 is legal, completes with ok, and changes nothing.
- mem_r and mem_w both high at acceptance: treated as a write; rdata is unchanged.
- Address range: upper address bits above the index field are ignored, so addresses wrap modulo DEPTH*8. Low bits [2:0] are ignored.
- busy=1 from the cycle after the accepting edge through DONE.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- When defined:
  - Adds output err (1 bit), valid with ok.
  - err=1 if the latched addr has any bit set above the index field, or if the access is misaligned. Misaligned means a read with addr[2:0]!=0, or a write whose set wstrb bits are not a contiguous, naturally aligned group of 1, 2, 4 or 8 bytes.
  - On err, the access is suppressed: no RAM write, rdata=0. ok still pulses and the FSM timing is unchanged.
  - err resets to 0.
- When not defined: no err port exists and no checks are made; wrap behaviour as above.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, then release with no request -> ok=0, busy=0, rdata=0 throughout.
- Write then read, LATENCY=2: write addr=0x10, wdata=0x1122334455667788, wstrb=0xFF, held until ok -> ok high exactly 2 edges after acceptance; then read 0x10 -> rdata=0x1122334455667788 with ok.
- Byte strobe: after the previous write, write wdata=0xAA00, wstrb=0x02 to addr 0x10; read -> rdata=0x112233445566AA88.
- Held request: hold mem_r=1 for 6 cycles after ok -> exactly one ok pulse; FSM stays in DONE until mem_r=0, then returns to IDLE.
- Reset mid-op: accept a write to 0x18, assert reset in WAIT; after release, read 0x18 -> prior contents, not the new data; ok=0 during and just after reset.
- MEM_RESP_ERR_EN:
  - read addr=0x13 -> ok=1, err=1, rdata=0;
  - write to an address with bit 40 set -> err=1 and the RAM is unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - data-memory responder with programmable latency
//
// Accepts a level-held read/write request, waits LATENCY edges, performs the
// access on an internal DEPTH x 64-bit RAM and pulses ok for one cycle.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   mem_r, mem_w      request levels, held by the initiator until ok
//   addr              byte address; word index = addr[$clog2(DEPTH)+2:3]
//   wdata, wstrb      write data and byte-lane enables
//   rdata             read data, valid with ok and held afterwards
//   ok                one-cycle completion pulse
//   busy              high in every state except IDLE
//   err               (only with MEM_RESP_ERR_EN) range/alignment error, valid with ok
//
// Optional feature macro: MEM_RESP_ERR_EN
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic [63:0] rdata,
  output logic        ok,
  output logic        busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        access;

  logic [63:0] addr_q, wdata_q;
  logic [7:0]  wstrb_q;
  logic        op_w_q;

  logic [63:0] mem [DEPTH];

  // With LATENCY=1 the access happens on the accepting edge itself, so the
  // live request inputs are used; otherwise the latched copies are.
  logic          acc_w;
  logic [63:0]   acc_addr, acc_wdata;
  logic [7:0]    acc_wstrb;
  logic [IW-1:0] acc_idx;
  logic          acc_err;
  logic          we;

  assign acc_w     = (state == IDLE) ? mem_w : op_w_q;
  assign acc_addr  = (state == IDLE) ? addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? wdata : wdata_q;
  assign acc_wstrb = (state == IDLE) ? wstrb : wstrb_q;
  assign acc_idx   = acc_addr[IW+2:3];

`ifdef MEM_RESP_ERR_EN
  logic strb_ok;
  always_comb begin
    strb_ok = 1'b0;
    case (acc_wstrb)
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF: strb_ok = 1'b1;
      default: strb_ok = 1'b0;
    endcase
  end
  assign acc_err = (|(acc_addr >> (IW + 3))) |
                   (acc_w ? ~strb_ok : (|acc_addr[2:0]));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[63:IW+3], acc_addr[2:0]};
  assign acc_err = 1'b0;
`endif

  assign we = access & acc_w & ~acc_err & ~reset;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_r | mem_w) begin
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: state_d = DONE;
      // Wait for the request to drop so a held level is not re-accepted.
      DONE: if (!mem_r && !mem_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ok   = (state == RESP);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      op_w_q  <= 1'b0;
      rdata   <= 64'd0;
`ifdef MEM_RESP_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && (mem_r || mem_w)) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        op_w_q  <= mem_w;
      end
      if (access && !acc_w) rdata <= acc_err ? 64'd0 : mem[acc_idx];
`ifdef MEM_RESP_ERR_EN
      if (access) err <= acc_err;
`endif
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int IW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_r = 1'b0, mem_w = 1'b0;
  logic [63:0] addr = 64'd0, wdata = 64'd0;
  logic [7:0]  wstrb = 8'd0;
  logic [63:0] rdata;
  logic        ok, busy;
`ifdef MEM_RESP_ERR_EN
  logic        err;
`endif

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
    .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ok(ok), .busy(busy)
`ifdef MEM_RESP_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] m [DEPTH];
  logic [63:0] exp_rd = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input bit w, input logic [63:0] a, input logic [7:0] s);
`ifdef MEM_RESP_ERR_EN
    bit good;
    if ((a >> (IW + 3)) != 64'd0) return 1'b1;
    if (!w) return a[2:0] != 3'd0;
    if (s == 8'd0) return 1'b0;
    good = 1'b0;
    for (int sz = 1; sz <= 8; sz = sz * 2)
      for (int off = 0; off < 8; off += sz)
        if (s == 8'(((1 << sz) - 1) << off)) good = 1'b1;
    return !good;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_op(input bit rq, input bit wq, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    int n;
    bit e;
    int idx;
    @(negedge clk);
    check("idle_before_req", busy, 1'b0);
    mem_r = rq; mem_w = wq; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    n = 1;
    // Disturb the request fields after acceptance; the DUT must use its copies.
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; wstrb = 8'($urandom);
    while (!ok && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
    e = model_err(wq, a, s);
    idx = int'(a[IW+2:3]);
    if (wq) begin
      if (!e)
        for (int b = 0; b < 8; b++)
          if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_rd = e ? 64'd0 : m[idx];
    end
    check("rdata", rdata, exp_rd);
    check("busy_resp", busy, 1'b1);
`ifdef MEM_RESP_ERR_EN
    check("err", err, e);
`endif
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0;
    @(posedge clk); #1;
    check("ok_single", ok, 1'b0);
    @(posedge clk); #1;
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [63:0] a, d;
    bit rq, wq;

    // Reset held for three cycles, then idle.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ok", ok, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdata", rdata, 64'd0);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ok", ok, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_rdata", rdata, 64'd0);
    end

    // Give every word a defined value.
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF);

    // Directed write / read / byte strobe.
    do_op(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 8'hFF);
    do_op(1'b1, 1'b0, 64'h10, 64'd0, 8'h00);
    check("plan_full_read", rdata, 64'h1122334455667788);
    do_op(1'b0, 1'b1, 64'h10, 64'hAA00, 8'h02);
    check("plan_after_write_rdata", rdata, 64'h1122334455667788);
    do_op(1'b1, 1'b0, 64'h10, 64'd0, 8'h00);
    check("plan_byte_read", rdata, 64'h112233445566AA88);

    // Zero-strobe write and simultaneous r/w (treated as a write).
    do_op(1'b0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    do_op(1'b1, 1'b1, 64'h28, 64'hDEAD_BEEF_0000_0001, 8'h0F);
    do_op(1'b1, 1'b0, 64'h28, 64'd0, 8'h00);

    // Held request: exactly one ok pulse, stays busy until the request drops.
    @(negedge clk);
    mem_r = 1'b1; addr = 64'h10;
    pulses = 0;
    repeat (LAT + 6) begin
      @(posedge clk); #1;
      if (ok) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_busy", busy, 1'b1);
    check("held_rdata", rdata, m[2]);
    exp_rd = m[2];
    @(negedge clk); mem_r = 1'b0;
    @(posedge clk); #1;
    check("held_release", busy, 1'b0);

    // Reset while a write waits: RAM must keep the old word.
    do_op(1'b0, 1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 8'hFF);
    @(negedge clk);
    mem_w = 1'b1; addr = 64'h18; wdata = 64'hFEDC_BA98_7654_3210; wstrb = 8'hFF;
    @(posedge clk); #1;
    check("midop_busy", busy, 1'b1);
    @(negedge clk); reset = 1'b1; mem_w = 1'b0;
    #1;
    check("midop_rst_ok", ok, 1'b0);
    check("midop_rst_busy", busy, 1'b0);
    check("midop_rst_rdata", rdata, 64'd0);
    exp_rd = 64'd0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midop_post_ok", ok, 1'b0);
    do_op(1'b1, 1'b0, 64'h18, 64'd0, 8'h00);
    check("midop_kept", rdata, 64'h0123_4567_89AB_CDEF);

    // Randomized traffic including wrapped addresses and random strobes.
    for (int k = 0; k < 60; k++) begin
      rq = 1'($urandom); wq = 1'($urandom);
      if (!rq && !wq) rq = 1'b1;
      a = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a[63:IW+3] = '0;
      d = {$urandom, $urandom};
      do_op(rq, wq, a, d, 8'($urandom));
    end

`ifdef MEM_RESP_ERR_EN
    do_op(1'b1, 1'b0, 64'h13, 64'd0, 8'h00);
    check("err_read_rdata", rdata, 64'd0);
    do_op(1'b0, 1'b1, 64'h10 | (64'h1 << 40), 64'h5555_5555_5555_5555, 8'hFF);
    do_op(1'b1, 1'b0, 64'h10, 64'd0, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
